// File: rtl/hazard_scoreboard.sv
// Decode-side hazard controller: tracks in-flight destination registers, raises stall/flush, counts stalls.
// Define FWD_EN to compile in forwarding selects and switch the hazard rule to load-use only.
module hazard_scoreboard #(
    parameter int NUM_STAGES   = 3,
    parameter int BRANCH_STAGE = 2,
    parameter int REG_ADDR_W   = 5,
    parameter int STALL_CNT_W  = 16,
    parameter int FWD_W        = $clog2(NUM_STAGES + 1)
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   IssueValid,
    input  logic [REG_ADDR_W-1:0]  SrcA,
    input  logic [REG_ADDR_W-1:0]  SrcB,
    input  logic                   SrcAUsed,
    input  logic                   SrcBUsed,
    input  logic [REG_ADDR_W-1:0]  DstReg,
    input  logic                   DstWrite,
    input  logic                   DstIsLoad,
    input  logic                   BranchTaken,
    output logic                   Stall,
    output logic                   Flush,
    output logic [FWD_W-1:0]       FwdA,
    output logic [FWD_W-1:0]       FwdB,
    output logic [NUM_STAGES-1:0]  InFlight,
    output logic [STALL_CNT_W-1:0] StallCount
);

    // Bit/index k-1 holds scoreboard entry k (the instruction in stage k).
    logic [NUM_STAGES-1:0]  valid_q, valid_d;
    logic [NUM_STAGES-1:0]  load_q, load_d;
    logic [REG_ADDR_W-1:0]  dst_q [NUM_STAGES];
    logic [REG_ADDR_W-1:0]  dst_d [NUM_STAGES];
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [NUM_STAGES-1:0]  match_a, match_b;
    logic                   hazard;
    logic                   accept;
    logic                   unused_load;

    always_comb begin
        match_a = '0;
        match_b = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            match_a[k] = SrcAUsed && valid_q[k] && (dst_q[k] == SrcA);
            match_b[k] = SrcBUsed && valid_q[k] && (dst_q[k] == SrcB);
        end
    end

`ifdef FWD_EN
    // Only a load still in EX cannot be forwarded in time.
    assign hazard = (match_a[0] || match_b[0]) && load_q[0];

    always_comb begin
        FwdA = '0;
        FwdB = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (match_a[k]) FwdA = FWD_W'(k + 1);
            if (match_b[k]) FwdB = FWD_W'(k + 1);
        end
    end
`else
    assign hazard = (|match_a) || (|match_b);
    assign FwdA   = '0;
    assign FwdB   = '0;
`endif

    assign Flush  = BranchTaken;
    assign Stall  = IssueValid && hazard && !BranchTaken;
    assign accept = IssueValid && !hazard && !BranchTaken;

    always_comb begin
        valid_d = '0;
        load_d  = '0;
        for (int k = 0; k < NUM_STAGES; k++) dst_d[k] = dst_q[k];

        valid_d[0] = accept && DstWrite && (DstReg != '0);
        load_d[0]  = DstIsLoad;
        dst_d[0]   = DstReg;
        for (int k = 1; k < NUM_STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            load_d[k]  = load_q[k-1];
            dst_d[k]   = dst_q[k-1];
        end

        // A taken branch squashes everything younger than and including the branch stage.
        if (Flush) begin
            for (int k = 0; k < BRANCH_STAGE; k++) valid_d[k] = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            valid_q     <= '0;
            load_q      <= '0;
            stall_cnt_q <= '0;
            for (int k = 0; k < NUM_STAGES; k++) dst_q[k] <= '0;
        end else begin
            valid_q     <= valid_d;
            load_q      <= load_d;
            stall_cnt_q <= stall_cnt_d;
            for (int k = 0; k < NUM_STAGES; k++) dst_q[k] <= dst_d[k];
        end
    end

    assign InFlight    = valid_q;
    assign StallCount  = stall_cnt_q;
    assign unused_load = ^load_q;

endmodule
